// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the execute-stage M-extension unit.
// Opcode/funct codes and FSM state encodings.
package ex_muldiv_pkg;

    localparam int DATA_WIDTH = 64;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// Restoring radix-2 divider datapath: one quotient bit per step.
// Final step applies sign fixup and W-form sign extension.
module ex_div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            w,
    input  logic            sgn,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]   cnt_q;
    logic            w_q, nq_q, nr_q;

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
    logic            sa, sb;
    logic [XLEN:0]   rem_sh, diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    // Operand preparation at load time: extend W operands, take magnitudes
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (w) begin
            a_ext = {{(XLEN-32){sgn & dividend[31]}}, dividend[31:0]};
            b_ext = {{(XLEN-32){sgn & divisor[31]}}, divisor[31:0]};
        end
        sa = sgn & a_ext[XLEN-1];
        sb = sgn & b_ext[XLEN-1];
        a_abs = sa ? -a_ext : a_ext;
        b_abs = sb ? -b_ext : b_ext;
    end

    // One restoring step plus the sign-fixed outputs of that step
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, div_q};
        ge     = ~diff[XLEN];
        rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ge};
        q_fix  = nq_q ? -quo_nx : quo_nx;
        r_fix  = nr_q ? -rem_nx : rem_nx;
        quotient  = q_fix;
        remainder = r_fix;
        if (w_q) begin
            quotient  = {{(XLEN-32){q_fix[31]}}, q_fix[31:0]};
            remainder = {{(XLEN-32){r_fix[31]}}, r_fix[31:0]};
        end
        last = step && (cnt_q == '0);
    end

    // Load on start, shift one bit per step
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            w_q   <= 1'b0;
            nq_q  <= 1'b0;
            nr_q  <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= w ? (a_abs << (XLEN-32)) : a_abs;
            div_q <= b_abs;
            cnt_q <= w ? CW'(31) : CW'(XLEN-1);
            w_q   <= w;
            nq_q  <= sa ^ sb;
            nr_q  <= sa;
        end else if (step) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage M-extension unit: registered multiply, iterative divide.
// Holds the pipeline until a one-cycle result strobe in DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = DATA_WIDTH
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [XLEN-1:0] Rs1ReadDataIn,
    input  logic [XLEN-1:0] Rs2ReadDataIn,
    input  logic [6:0]      OpCodeIn,
    input  logic [2:0]      Funct3In,
    input  logic [6:0]      Funct7In,
    output logic            MulDivHoldReq,
    output logic [XLEN-1:0] MulDivResult,
    output logic            MulDivResultValid
);

    muldiv_state_e state_q, state_d;

    logic [XLEN-1:0] a_q, b_q, res_q;
    logic [2:0]      f3_q;
    logic            w_q;

    logic            f3_w_ok, muldiv_op, w_in;
    logic            is_div, is_rem, sgn_div;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] a_eff, spec_res;

    logic                   a_sg, b_sg;
    logic signed [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]        mul_res;

    logic            div_start, div_step, div_last;
    logic [XLEN-1:0] div_quo, div_rem;

    // Decode and divide special-case detection on the ID/EX inputs
    always_comb begin
        f3_w_ok = Funct3In inside {F3_MUL, F3_DIV, F3_DIVU,
                                   F3_REM, F3_REMU};
        w_in = OpCodeIn == OPC_OP32;
        muldiv_op = (Funct7In == F7_MULDIV) &&
                    ((OpCodeIn == OPC_OP) || (w_in && f3_w_ok));
        is_div  = Funct3In[2];
        is_rem  = Funct3In[1];
        sgn_div = ~Funct3In[0];
        a_eff = w_in ? {{(XLEN-32){Rs1ReadDataIn[31]}},
                        Rs1ReadDataIn[31:0]}
                     : Rs1ReadDataIn;
        if (w_in) begin
            div_zero = Rs2ReadDataIn[31:0] == 32'd0;
            ovf = sgn_div &&
                  (Rs1ReadDataIn[31:0] == 32'h8000_0000) &&
                  (Rs2ReadDataIn[31:0] == 32'hFFFF_FFFF);
        end else begin
            div_zero = Rs2ReadDataIn == '0;
            ovf = sgn_div &&
                  (Rs1ReadDataIn == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (Rs2ReadDataIn == '1);
        end
        special = is_div && (div_zero || ovf);
        if (div_zero)
            spec_res = is_rem ? a_eff : '1;
        else
            spec_res = is_rem ? '0 : a_eff;
    end

    // Full-width product of the latched operands
    always_comb begin
        a_sg = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
        b_sg = f3_q == F3_MULH;
        ma = {{XLEN{a_sg & a_q[XLEN-1]}}, a_q};
        mb = {{XLEN{b_sg & b_q[XLEN-1]}}, b_q};
        prod = ma * mb;
        unique case (f3_q)
            F3_MUL:
                mul_res = w_q ? {{(XLEN-32){prod[31]}}, prod[31:0]}
                              : prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:
                mul_res = prod[2*XLEN-1:XLEN];
            default:
                mul_res = prod[XLEN-1:0];
        endcase
    end

    assign div_start = (state_q == S_IDLE) && muldiv_op &&
                       is_div && !special;
    assign div_step  = state_q == S_DIV;

    ex_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (Clk),
        .rst       (Rst),
        .start     (div_start),
        .step      (div_step),
        .w         (w_in),
        .sgn       (sgn_div),
        .dividend  (Rs1ReadDataIn),
        .divisor   (Rs2ReadDataIn),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and hold request
    always_comb begin
        state_d = state_q;
        MulDivHoldReq = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (muldiv_op) begin
                    MulDivHoldReq = 1'b1;
                    if (!is_div)      state_d = S_MUL;
                    else if (special) state_d = S_DONE;
                    else              state_d = S_DIV;
                end
            end
            S_MUL: begin
                MulDivHoldReq = 1'b1;
                state_d = S_DONE;
            end
            S_DIV: begin
                MulDivHoldReq = 1'b1;
                if (div_last) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch and result register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            w_q   <= 1'b0;
            res_q <= '0;
        end else begin
            if (state_q == S_IDLE && muldiv_op) begin
                a_q  <= Rs1ReadDataIn;
                b_q  <= Rs2ReadDataIn;
                f3_q <= Funct3In;
                w_q  <= w_in;
                if (special) res_q <= spec_res;
            end
            if (state_q == S_MUL) res_q <= mul_res;
            if (div_last) res_q <= f3_q[1] ? div_rem : div_quo;
        end
    end

    assign MulDivResult      = res_q;
    assign MulDivResultValid = state_q == S_DONE;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv.
// Checks latency, hold request, results and reset abort.
module tb_ex_muldiv;

    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OP32 = 7'b0111011;
    localparam logic [6:0] M7   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rs1, rs2;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        hold, valid;
    logic [63:0] res;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(64)) dut (
        .Clk               (clk),
        .Rst               (rst),
        .Rs1ReadDataIn     (rs1),
        .Rs2ReadDataIn     (rs2),
        .OpCodeIn          (opc),
        .Funct3In          (f3),
        .Funct7In          (f7),
        .MulDivHoldReq     (hold),
        .MulDivResult      (res),
        .MulDivResultValid (valid)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nop();
        opc = 7'd0;
        f3  = 3'd0;
        f7  = 7'd0;
        rs1 = '0;
        rs2 = '0;
    endtask

    // Issue at a negedge (cycle T), follow to the Valid cycle
    task automatic run_op(input string tag,
                          input logic [6:0] o,
                          input logic [2:0] fn3,
                          input logic [63:0] a,
                          input logic [63:0] b,
                          input logic [63:0] exp,
                          input int lat);
        int cyc;
        logic [63:0] seen;
        @(negedge clk);
        opc = o; f3 = fn3; f7 = M7; rs1 = a; rs2 = b;
        #1;
        chk({tag, " hold@T"}, 64'(hold), 64'd1);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (valid || cyc > 100) break;
            chk({tag, " hold busy"}, 64'(hold), 64'd1);
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, res, exp);
        chk({tag, " hold@valid"}, 64'(hold), 64'd0);
        seen = res;
        #1 nop();
        @(negedge clk);
        chk({tag, " valid pulse"}, 64'(valid), 64'd0);
        chk({tag, " result held"}, res, seen);
    endtask

    // Non-MulDiv encodings must not raise hold
    task automatic no_op(input string tag,
                         input logic [6:0] o,
                         input logic [2:0] fn3,
                         input logic [6:0] fn7);
        @(negedge clk);
        opc = o; f3 = fn3; f7 = fn7; rs1 = 64'd3; rs2 = 64'd5;
        #1;
        chk({tag, " hold"}, 64'(hold), 64'd0);
        @(negedge clk);
        chk({tag, " valid"}, 64'(valid), 64'd0);
        chk({tag, " hold next"}, 64'(hold), 64'd0);
        nop();
    endtask

    initial begin
        int vcnt;
        rst = 1'b1;
        nop();
        repeat (3) @(negedge clk);
        chk("reset hold", 64'(hold), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset result", res, 64'd0);
        rst = 1'b0;

        run_op("MUL", OP, 3'd0, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 2);
        run_op("MULHU", OP, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd2, 64'd1, 2);
        run_op("MULHSU", OP, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("MULW", OP32, 3'd0, 64'h0000_0001_0001_0000,
               64'h0000_0000_0001_0000,
               64'h0000_0000_0000_0000, 2);
        run_op("DIVU", OP, 3'd5, 64'd100, 64'd7, 64'd14, 65);
        run_op("REMU", OP, 3'd7, 64'd100, 64'd7, 64'd2, 65);
        run_op("DIV", OP, 3'd4, 64'hFFFF_FFFF_FFFF_FF9C,
               64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("REM", OP, 3'd6, 64'hFFFF_FFFF_FFFF_FF9C,
               64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("DIV/0", OP, 3'd4, 64'd5, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("REM/0", OP, 3'd6, 64'd5, 64'd0, 64'd5, 1);
        run_op("DIV ovf", OP, 3'd4, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("REM ovf", OP, 3'd6, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("REMW", OP32, 3'd6, 64'h0000_0000_FFFF_FFF9,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("DIVUW", OP32, 3'd5, 64'h0000_0001_0000_0010,
               64'd4, 64'd4, 33);
        run_op("DIVW", OP32, 3'd4, 64'h0000_0000_FFFF_FFF9,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);

        no_op("ADD", OP, 3'd0, 7'd0);
        no_op("MULHW", OP32, 3'd1, M7);

        // Reset during the 10th divide iteration
        @(negedge clk);
        opc = OP; f3 = 3'd5; f7 = M7; rs1 = 64'd100; rs2 = 64'd7;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        nop();
        @(negedge clk);
        chk("rst abort hold", 64'(hold), 64'd0);
        chk("rst abort valid", 64'(valid), 64'd0);
        rst = 1'b0;
        vcnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("rst abort no pulse", 64'(vcnt), 64'd0);

        run_op("MUL after rst", OP, 3'd0, 64'd3, 64'd5, 64'd15, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage M-extension unit; consumes the ID/EX register outputs directly (operands, OpCode, Funct3, Funct7).
- Single-cycle-issue multiply; iterative radix-2 divide.
- Drives a hold request into the pipeline controller, which freezes the ID/EX register until the result is ready.
- The Ex result mux selects MulDivResult when MulDivResultValid is high.

Parameters:
- XLEN, 64, datapath width; must equal `DataWidth.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Rs1ReadDataIn  in  XLEN  operand A from ID/EX
- Rs2ReadDataIn  in  XLEN  operand B from ID/EX
- OpCodeIn  in  7  opcode from ID/EX
- Funct3In  in  3  funct3 from ID/EX
- Funct7In  in  7  funct7 from ID/EX
- MulDivHoldReq  out  1  stall request to controller
- MulDivResult  out  XLEN  result
- MulDivResultValid  out  1  one-cycle result strobe

Behaviour:
- Op decode: MulDivOp = Funct7In==7'b0000001 and OpCodeIn is either 7'b0110011 (OP) or 7'b0111011 (OP-32, W form).
- Funct3 mapping: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- W forms allow only funct3 0, 4, 5, 6, 7. W funct3 1–3 is not MulDivOp.
- W forms use operand bits [31:0]; the result is the 32-bit result sign-extended to XLEN.
- Reset values: state IDLE, MulDivResult=0, MulDivResultValid=0, MulDivHoldReq=0; iteration counter and work registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If MulDivOp: MulDivHoldReq=1 combinationally in the same cycle; latch operands, op and W flag.
  - Divide special cases are detected in this cycle:
    - Divisor==0: quotient = all ones; remainder = dividend (W forms: 32-bit values, sign-extended).
    - Signed overflow (most negative / -1): quotient = dividend; remainder = 0.
    - Special case -> go to DONE with the result registered.
  - Otherwise: multiply -> MUL; divide -> DIV.
  - Non-MulDivOp -> stay IDLE; HoldReq=0.
- MUL:
  - Full 2*XLEN product of the latched operands, with signedness per op.
  - Result select: low half for MUL/MULW (MULW then sign-extended from bit 31); high half for MULH/MULHSU/MULHU.
  - Result is registered; go to DONE. HoldReq=1.
- DIV:
  - Restoring radix-2 on absolute values (signed ops) or raw values (unsigned ops).
  - One quotient bit per cycle; N=XLEN iterations, or 32 for W forms.
  - Counter counts N-1 down to 0. The final iteration also applies sign fixup:
    - quotient negative iff operand signs differ;
    - remainder takes the dividend's sign.
  - The selected quotient/remainder is registered; go to DONE. HoldReq=1.
- DONE:
  - MulDivResultValid=1 and HoldReq=0 for exactly one cycle; then IDLE unconditionally.
  - ID/EX still presents the same instruction this cycle. DONE must not restart it; it advances on the following edge.
- Latency from IDLE accept cycle T to the Valid cycle:
  - multiply: T+2;
  - divide: T+N+1 (65 for 64-bit, 33 for W);
  - special-case divide: T+1.
- MulDivResult holds its value outside Valid cycles.
- Rst mid-operation: return to IDLE on that edge; HoldReq and Valid are 0 the next cycle; no result is produced.
- Operand inputs are ignored outside IDLE.

Decomposition:
- Shared defines (existing defines file): MulDiv funct7 code, OP/OP-32 opcodes, funct3 codes for the eight ops, state encodings.
- One natural sub-module: ex_div_iter (restoring divider datapath: remainder/quotient shift registers, counter, sign fixup).
- Multiply and FSM stay in ex_muldiv.

Test Plan:
- MUL, rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD -> Valid at T+2, result 0xFFFF_FFFF_FFFF_FFEB; HoldReq high at T and T+1, low at T+2.
- MULHU, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> result 1.
- MULHSU, rs1=-1, rs2=2 -> result 0xFFFF_FFFF_FFFF_FFFF.
- DIVU, rs1=100, rs2=7 -> Valid at T+65, result 14.
- REMU, same operands -> result 2.
- DIV, rs1=-100, rs2=7 -> result -14.
- REM, same operands -> result -2.
- DIV by zero, rs1=5 -> Valid at T+1, result 0xFFFF_FFFF_FFFF_FFFF.
- REM by zero, rs1=5 -> result 5.
- DIV, rs1=0x8000_0000_0000_0000, rs2=-1 -> result 0x8000_0000_0000_0000.
- REM, same operands -> result 0.
- REMW, rs1=0x0000_0000_FFFF_FFF9 (-7 in 32-bit), rs2=2 -> Valid at T+33, result 0xFFFF_FFFF_FFFF_FFFF.
- DIVUW, rs1=0x1_0000_0010, rs2=4 -> result 4.
- Rst asserted during the 10th DIV iteration -> IDLE next cycle, HoldReq=0, no Valid pulse.
- Rst asserted during the 10th DIV iteration, then a fresh MUL 3*5 -> result 15 at T+2.
